// File: rtl/seg_scan_capture.sv
// seg_scan_capture: rebuilds a 4-digit multiplexed display frame from its scan lines.
// Define SEG_SCAN_CAPTURE_HEX_EN to add the hex/hex_bad glyph decode outputs.
module seg_scan_capture #(
  parameter int unsigned SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        seg_P,
  output logic [27:0] seg_raw,
  output logic [1:0]  ptr,
  output logic        ptr_valid,
  output logic        frame_done,
`ifdef SEG_SCAN_CAPTURE_HEX_EN
  output logic [15:0] hex,
  output logic [3:0]  hex_bad,
`endif
  output logic        err
);

  localparam logic [1:0] ST_WAIT     = 2'd0;
  localparam logic [1:0] ST_SETTLE   = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [7:0]  next_cnt;
  logic [3:0]  prev_an;
  logic [3:0]  captured;
  logic [3:0]  captured_next;
  logic [3:0]  cap_vec;
  logic [3:0]  pt_buf;
  logic [3:0]  lit;
  logic [27:0] seg_buf;
  logic        changed;
  logic        settle_hit;
  logic        an_ok;
  logic        an_blank;
  logic        frame_full;
  logic [2:0]  lit_cnt;

  function automatic logic an_legal(input logic [3:0] a);
    case (a)
      4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111: an_legal = 1'b1;
      default:                                     an_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] count4(input logic [3:0] v);
    count4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [1:0] lit_index(input logic [3:0] v);
    case (v)
      4'b0001: lit_index = 2'd0;
      4'b0010: lit_index = 2'd1;
      4'b0100: lit_index = 2'd2;
      4'b1000: lit_index = 2'd3;
      default: lit_index = 2'd0;
    endcase
  endfunction

  // Settle timing, capture enables and frame completion.
  always_comb begin
    changed  = (an != prev_an);
    an_ok    = an_legal(an);
    an_blank = (an == 4'b1111);
    if (changed) begin
      next_cnt = 8'd0;
    end else begin
      next_cnt = cnt + 8'd1;
    end
    // The cycle an changes already counts as the first stable cycle.
    if ((changed || (state == ST_SETTLE)) && (next_cnt == SETTLE_LAST)) begin
      settle_hit = 1'b1;
    end else begin
      settle_hit = 1'b0;
    end
    if (settle_hit && an_ok && !an_blank) begin
      cap_vec = ~an;
    end else begin
      cap_vec = 4'b0000;
    end
    frame_full = (captured == 4'b1111);
    if (frame_full) begin
      captured_next = cap_vec;
    end else begin
      captured_next = captured | cap_vec;
    end
    lit     = ~pt_buf;
    lit_cnt = count4(lit);
  end

  // Scan tracking, working buffer and published frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_WAIT;
      cnt        <= 8'd0;
      prev_an    <= 4'b1111;
      captured   <= 4'b0000;
      seg_buf    <= 28'hFFFFFFF;
      pt_buf     <= 4'b1111;
      seg_raw    <= 28'hFFFFFFF;
      ptr        <= 2'd0;
      ptr_valid  <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      prev_an  <= an;
      captured <= captured_next;
      if (settle_hit) begin
        state <= ST_HELD;
        cnt   <= 8'd0;
      end else if (changed) begin
        state <= ST_SETTLE;
        cnt   <= 8'd0;
      end else if (state == ST_SETTLE) begin
        cnt <= next_cnt;
      end else begin
        cnt <= cnt;
      end
      for (int i = 0; i < 4; i++) begin
        if (cap_vec[i]) begin
          seg_buf[7*i +: 7] <= seg;
          pt_buf[i]         <= seg_P;
        end
      end
      frame_done <= frame_full;
      if (frame_full) begin
        seg_raw <= seg_buf;
        if (lit_cnt == 3'd1) begin
          ptr       <= lit_index(lit);
          ptr_valid <= 1'b1;
        end else begin
          ptr_valid <= 1'b0;
        end
      end
      if ((settle_hit && !an_ok) || (frame_full && (lit_cnt > 3'd1))) begin
        err <= 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_CAPTURE_HEX_EN
  logic [15:0] hex_next;
  logic [3:0]  bad_next;

  // Active-low glyph to {bad, nibble}; anything outside the 16 glyphs is bad.
  function automatic logic [4:0] hex_decode(input logic [6:0] s);
    case (s)
      7'h40:   hex_decode = 5'h00;
      7'h79:   hex_decode = 5'h01;
      7'h24:   hex_decode = 5'h02;
      7'h30:   hex_decode = 5'h03;
      7'h19:   hex_decode = 5'h04;
      7'h12:   hex_decode = 5'h05;
      7'h02:   hex_decode = 5'h06;
      7'h78:   hex_decode = 5'h07;
      7'h00:   hex_decode = 5'h08;
      7'h10:   hex_decode = 5'h09;
      7'h08:   hex_decode = 5'h0A;
      7'h03:   hex_decode = 5'h0B;
      7'h46:   hex_decode = 5'h0C;
      7'h21:   hex_decode = 5'h0D;
      7'h06:   hex_decode = 5'h0E;
      7'h0E:   hex_decode = 5'h0F;
      default: hex_decode = 5'h10;
    endcase
  endfunction

  // Decode the working buffer so hex lands together with seg_raw.
  always_comb begin
    hex_next = 16'h0000;
    bad_next = 4'h0;
    for (int i = 0; i < 4; i++) begin
      {bad_next[i], hex_next[4*i +: 4]} = hex_decode(seg_buf[7*i +: 7]);
    end
  end

  // Published hex digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      hex     <= 16'h0000;
      hex_bad <= 4'hF;
    end else if (frame_full) begin
      hex     <= hex_next;
      hex_bad <= bad_next;
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scans plus random scan traffic checked against
// a frame-level model; hex outputs checked when SEG_SCAN_CAPTURE_HEX_EN is defined.
module tb_seg_scan_capture;
  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        seg_P;
  logic [27:0] seg_raw;
  logic [1:0]  ptr;
  logic        ptr_valid;
  logic        frame_done;
  logic        err;
`ifdef SEG_SCAN_CAPTURE_HEX_EN
  logic [15:0] hex;
  logic [3:0]  hex_bad;
`endif

  int total = 0;
  int bad = 0;
  int fd_cnt = 0;

  // model state
  logic [3:0]  m_prev;
  int          m_run;
  bit          m_armed;
  bit          m_cap [4];
  logic [6:0]  m_dig [4];
  logic        m_pt  [4];
  logic [27:0] e_raw;
  logic [1:0]  e_ptr;
  logic        e_valid, e_fd, e_err;
  logic [15:0] e_hex;
  logic [3:0]  e_bad;

  seg_scan_capture #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .seg_P(seg_P),
    .seg_raw(seg_raw), .ptr(ptr), .ptr_valid(ptr_valid), .frame_done(frame_done),
`ifdef SEG_SCAN_CAPTURE_HEX_EN
    .hex(hex), .hex_bad(hex_bad),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] hex_model(input logic [6:0] d);
    logic [6:0] on_pat [16];
    on_pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    hex_model = 5'h10;
    for (int k = 0; k < 16; k++) begin
      if ((~on_pat[k]) == d) hex_model = {1'b0, 4'(k)};
    end
  endfunction

  task automatic model_step(input logic r, input logic [3:0] a, input logic [6:0] s, input logic p);
    int nlit, lit_i, nz, idx;
    logic [4:0] hd;
    if (r) begin
      m_prev = 4'hF; m_run = 0; m_armed = 0;
      for (int i = 0; i < 4; i++) m_cap[i] = 0;
      e_raw = 28'hFFFFFFF; e_ptr = 2'd0; e_valid = 1'b0; e_fd = 1'b0; e_err = 1'b0;
      e_hex = 16'h0000; e_bad = 4'hF;
    end else begin
      e_fd = 1'b0;
      if (m_cap[0] && m_cap[1] && m_cap[2] && m_cap[3]) begin
        e_fd = 1'b1; nlit = 0; lit_i = 0;
        for (int i = 0; i < 4; i++) begin
          e_raw[7*i +: 7] = m_dig[i];
          if (!m_pt[i]) begin nlit++; lit_i = i; end
          m_cap[i] = 0;
          hd = hex_model(m_dig[i]);
          e_bad[i] = hd[4];
          e_hex[4*i +: 4] = hd[3:0];
        end
        if (nlit == 1) begin e_ptr = 2'(lit_i); e_valid = 1'b1; end
        else e_valid = 1'b0;
        if (nlit > 1) e_err = 1'b1;
      end
      if (a != m_prev) begin m_run = 1; m_armed = 1; end
      else if (m_run < 1000) m_run++;
      m_prev = a;
      if (m_armed && m_run == SETTLE) begin
        m_armed = 0; nz = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (a[i] == 1'b0) begin nz++; idx = i; end
        if (nz == 1) begin m_dig[idx] = s; m_pt[idx] = p; m_cap[idx] = 1; end
        else if (nz > 1) e_err = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] a, input logic [6:0] s, input logic p);
    rst = r; an = a; seg = s; seg_P = p;
    @(posedge clk);
    model_step(r, a, s, p);
    #1;
    chk("seg_raw", 32'(seg_raw), 32'(e_raw));
    chk("ptr", 32'(ptr), 32'(e_ptr));
    chk("ptr_valid", 32'(ptr_valid), 32'(e_valid));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("err", 32'(err), 32'(e_err));
`ifdef SEG_SCAN_CAPTURE_HEX_EN
    chk("hex", 32'(hex), 32'(e_hex));
    chk("hex_bad", 32'(hex_bad), 32'(e_bad));
`endif
    if (frame_done) fd_cnt++;
  endtask

  task automatic scan(input int idx, input logic [6:0] s, input logic p, input int cycles);
    logic [3:0] a;
    a = 4'hF;
    a[idx] = 1'b0;
    repeat (cycles) step(1'b0, a, s, p);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_seg_raw"}, 32'(seg_raw), 32'h0FFFFFFF);
    chk({tag, "_ptr"}, 32'(ptr), 32'd0);
    chk({tag, "_ptr_valid"}, 32'(ptr_valid), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
`ifdef SEG_SCAN_CAPTURE_HEX_EN
    chk({tag, "_hex"}, 32'(hex), 32'd0);
    chk({tag, "_hex_bad"}, 32'(hex_bad), 32'hF);
`endif
  endtask

  initial begin
    repeat (3) step(1'b1, 4'hF, 7'h7F, 1'b1);
    check_reset_vals("reset");

    // plain '0' on all digits, no points
    fd_cnt = 0;
    for (int d = 0; d < 4; d++) scan(d, 7'b1000000, 1'b1, 6);
    chk("zero_frame_count", 32'(fd_cnt), 32'd1);
    chk("zero_frame_raw", 32'(seg_raw), 32'h08102040);
    chk("zero_frame_valid", 32'(ptr_valid), 32'd0);
    chk("zero_frame_err", 32'(err), 32'd0);

    // point lit on digit 2 only
    for (int d = 0; d < 4; d++) scan(d, 7'b1000000, (d == 2) ? 1'b0 : 1'b1, 6);
    chk("point_ptr", 32'(ptr), 32'd2);
    chk("point_valid", 32'(ptr_valid), 32'd1);

    // digit 1 too short to settle
    fd_cnt = 0;
    scan(0, 7'h79, 1'b1, 6);
    scan(1, 7'h24, 1'b1, 3);
    scan(2, 7'h30, 1'b1, 6);
    scan(3, 7'h19, 1'b1, 6);
    chk("short_no_frame", 32'(fd_cnt), 32'd0);
    scan(1, 7'h24, 1'b1, 4);
    step(1'b0, 4'hF, 7'h7F, 1'b1);
    chk("short_then_frame", 32'(fd_cnt), 32'd1);
    chk("short_raw", 32'(seg_raw), {4'h0, 7'h19, 7'h30, 7'h24, 7'h79});

    // reset mid-frame discards partial captures
    scan(0, 7'h00, 1'b1, 6);
    scan(1, 7'h00, 1'b1, 6);
    step(1'b1, 4'hF, 7'h7F, 1'b1);
    check_reset_vals("midrst");
    fd_cnt = 0;
    scan(2, 7'h40, 1'b1, 6);
    scan(3, 7'h40, 1'b1, 6);
    scan(0, 7'h40, 1'b1, 6);
    chk("midrst_no_frame", 32'(fd_cnt), 32'd0);
    scan(1, 7'h40, 1'b1, 6);
    chk("midrst_frame", 32'(fd_cnt), 32'd1);

    // illegal anode pattern makes err sticky until reset
    repeat (4) step(1'b0, 4'b1100, 7'h40, 1'b1);
    step(1'b0, 4'hF, 7'h7F, 1'b1);
    chk("illegal_err", 32'(err), 32'd1);
    for (int d = 0; d < 4; d++) scan(d, 7'b1000000, 1'b1, 6);
    chk("illegal_sticky", 32'(err), 32'd1);
    step(1'b1, 4'hF, 7'h7F, 1'b1);
    chk("illegal_cleared", 32'(err), 32'd0);

`ifdef SEG_SCAN_CAPTURE_HEX_EN
    scan(0, 7'b0000000, 1'b1, 6);
    scan(1, 7'b0001000, 1'b1, 6);
    scan(2, 7'b1111110, 1'b1, 6);
    scan(3, 7'b1000000, 1'b1, 6);
    step(1'b0, 4'hF, 7'h7F, 1'b1);
    chk("hex_value", 32'(hex), 32'h000000A8);
    chk("hex_bad_value", 32'(hex_bad), 32'h4);
`endif

    // random scan traffic
    for (int n = 0; n < 600; n++) begin
      int kind, len;
      logic [3:0] a;
      logic [6:0] s;
      logic p;
      kind = $urandom_range(0, 59);
      len = $urandom_range(1, 8);
      s = 7'($urandom);
      p = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      if (kind == 0) begin
        step(1'b1, 4'($urandom), s, p);
      end else begin
        if (kind < 3) begin
          a = 4'($urandom);
          if ($countones(~a) < 2) a = 4'b0011;
        end else if (kind < 7) begin
          a = 4'hF;
        end else begin
          a = 4'hF;
          a[$urandom_range(0, 3)] = 1'b0;
        end
        for (int c = 0; c < len; c++) begin
          if ($urandom_range(0, 3) == 0) s = 7'($urandom);
          if ($urandom_range(0, 5) == 0) p = ~p;
          step(1'b0, a, s, p);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
